// File: rtl/gelu_pkg.sv
// Shared constants and types for the GELU LUT address serializer.
//  DATA_W/ADDR_W/IN_SHIFT : default element, address and quantizer shift widths
//  LUT_MIN_Q/LUT_MAX_Q    : raw Q8.8 range covered by the LUT, [-4.0, 4.0)
//  LUT_CENTRE             : address bias that maps q=0 to the table midpoint
//  q88_t                  : signed Q8.8 element
//  state_t                : serializer FSM state
package gelu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned IN_SHIFT = 3;

  localparam int LUT_MIN_Q  = -1024;
  localparam int LUT_MAX_Q  = 1023;
  localparam int LUT_CENTRE = 128;

  typedef logic signed [DATA_W-1:0] q88_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/gelu_quantize.sv
// Combinational quantizer: maps a signed Q8.8 element onto the 256-entry LUT
// address space ([-4.0, 4.0), step 1/32) and flags out-of-range inputs.
//  x     : raw signed element
//  addr  : LUT address (0 when under, all-ones when over)
//  over  : x above the LUT range
//  under : x below the LUT range
module gelu_quantize
  import gelu_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IN_SHIFT = 3
) (
  input  logic [DATA_W-1:0] x,
  output logic [ADDR_W-1:0] addr,
  output logic              over,
  output logic              under
);

  localparam logic signed [DATA_W-1:0] MIN_X  = DATA_W'(LUT_MIN_Q);
  localparam logic signed [DATA_W-1:0] MAX_X  = DATA_W'(LUT_MAX_Q);
  localparam logic signed [DATA_W-1:0] CENTRE = DATA_W'(LUT_CENTRE);

  logic signed [DATA_W-1:0] xs;
  logic signed [DATA_W-1:0] q;

  always_comb begin
    xs    = $signed(x);
    // Arithmetic shift floors toward -inf, matching the LUT step boundaries.
    q     = xs >>> IN_SHIFT;
    under = (xs < MIN_X);
    over  = (xs > MAX_X);
    addr  = ADDR_W'(q + CENTRE);
    if (under) begin
      addr = '0;
    end else if (over) begin
      addr = '1;
    end
  end

endmodule

// File: rtl/gelu_addr_serializer.sv
// Feeder for the GELU LUT activation stage. Accepts beats of LANES signed Q8.8
// elements over valid/ready and emits one quantized LUT address per cycle,
// with range flags and the raw element carried alongside.
//  clk, rst   : clock, synchronous active-high reset
//  s_valid    : input beat valid
//  s_ready    : input beat accepted when s_valid && s_ready
//  s_data     : packed elements, lane 0 in the low DATA_W bits
//  s_last     : beat ends a vector
//  lut_valid  : address valid (LUT stage in_valid)
//  lut_addr   : LUT address
//  sb_over    : x above range, LUT result replaced by x
//  sb_under   : x below range, LUT result replaced by 0
//  sb_x       : raw element
//  sb_lane    : lane index of the current element
//  sb_last    : final lane of a beat that carried s_last
module gelu_addr_serializer
  import gelu_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IN_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [LANES*DATA_W-1:0]    s_data,
  input  logic                       s_last,
  output logic                       lut_valid,
  output logic [ADDR_W-1:0]          lut_addr,
  output logic                       sb_over,
  output logic                       sb_under,
  output logic [DATA_W-1:0]          sb_x,
  output logic [$clog2(LANES)-1:0]   sb_lane,
  output logic                       sb_last
);

  localparam int unsigned CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              load;
  logic              ready_c;
  logic              emit;

  logic [DATA_W-1:0] beat_q [LANES];
  logic              beat_last_q;
  logic [DATA_W-1:0] elem;

  logic [ADDR_W-1:0] q_addr;
  logic              q_over;
  logic              q_under;

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic              over_q;
  logic              under_q;
  logic [DATA_W-1:0] x_q;
  logic [CNT_W-1:0]  lane_q;
  logic              last_q;

  assign emit = (state == ST_BUSY);
  assign elem = beat_q[cnt];

  gelu_quantize #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .IN_SHIFT (IN_SHIFT)
  ) u_quantize (
    .x     (elem),
    .addr  (q_addr),
    .over  (q_over),
    .under (q_under)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    load    = 1'b0;
    ready_c = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (s_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt + CNT_W'(1);
        // Accepting during the last lane keeps the output stream gap-free.
        if (cnt == LAST_LANE) begin
          ready_c = 1'b1;
          if (s_valid) begin
            load  = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        beat_q[i] <= '0;
      end
      beat_last_q <= 1'b0;
    end else if (load) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        beat_q[i] <= s_data[i*DATA_W +: DATA_W];
      end
      beat_last_q <= s_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
      x_q     <= '0;
      lane_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        addr_q  <= q_addr;
        over_q  <= q_over;
        under_q <= q_under;
        x_q     <= elem;
        lane_q  <= cnt;
        last_q  <= beat_last_q && (cnt == LAST_LANE);
      end
    end
  end

  // Outputs are forced low for the whole reset window, not only after the
  // first reset edge, so the downstream stage never sees stale data.
  assign s_ready   = ready_c & ~rst;
  assign lut_valid = valid_q & ~rst;
  assign lut_addr  = rst ? '0 : addr_q;
  assign sb_over   = over_q & ~rst;
  assign sb_under  = under_q & ~rst;
  assign sb_x      = rst ? '0 : x_q;
  assign sb_lane   = rst ? '0 : lane_q;
  assign sb_last   = last_q & ~rst;

endmodule

// File: tb/tb_gelu_addr_serializer.sv
module tb_gelu_addr_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        lut_valid;
  logic [7:0]  lut_addr;
  logic        sb_over;
  logic        sb_under;
  logic [15:0] sb_x;
  logic [1:0]  sb_lane;
  logic        sb_last;

  gelu_addr_serializer #(
    .LANES    (4),
    .DATA_W   (16),
    .ADDR_W   (8),
    .IN_SHIFT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .lut_valid (lut_valid),
    .lut_addr  (lut_addr),
    .sb_over   (sb_over),
    .sb_under  (sb_under),
    .sb_x      (sb_x),
    .sb_lane   (sb_lane),
    .sb_last   (sb_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic        over;
    logic        under;
    logic [15:0] x;
    logic [1:0]  lane;
    logic        last;
  } out_t;

  typedef struct {
    int   due;
    out_t o;
  } pend_t;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  addr;
    logic        over;
    logic        under;
  } vec_t;

  pend_t exp_q[$];
  out_t  cap[$];
  out_t  hold = '0;
  bit    cap_en = 1'b0;
  bit    exp_ready = 1'b0;
  int    cyc = 0;
  int    run = 0;
  int    max_run = 0;
  int    vcount = 0;
  int    passed = 0;
  int    total = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference: LUT covers [-4.0, 4.0) in steps of 1/32 (8 raw Q8.8 units).
  function automatic out_t model(logic [15:0] raw, int lane, bit last);
    out_t r;
    int   x;
    int   q;
    r      = '0;
    x      = int'($signed(raw));
    r.x    = raw;
    r.lane = 2'(lane);
    r.last = last && (lane == 3);
    if (x < -1024) begin
      r.under = 1'b1;
    end else if (x > 1023) begin
      r.over = 1'b1;
      r.addr = 8'd255;
    end else begin
      q      = (x >= 0) ? x / 8 : -((-x + 7) / 8);
      r.addr = 8'(q + 128);
    end
    return r;
  endfunction

  task automatic tick();
    bit          hs;
    bit          ev;
    logic [63:0] d;
    bit          l;
    pend_t       p;
    out_t        act;
    hs = s_valid && exp_ready && !rst;
    d  = s_data;
    l  = s_last;
    @(posedge clk);
    cyc++;
    #1;
    ev = 1'b0;
    if (rst) begin
      exp_q.delete();
      hold = '0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        ev   = 1'b1;
        hold = exp_q[0].o;
        void'(exp_q.pop_front());
      end
      if (hs) begin
        for (int k = 0; k < 4; k++) begin
          p.due = cyc + 1 + k;
          p.o   = model(d[16*k +: 16], k, l);
          exp_q.push_back(p);
        end
      end
    end
    exp_ready = !rst && (exp_q.size() <= 1);
    act = {lut_addr, sb_over, sb_under, sb_x, sb_lane, sb_last};
    check("lut_valid", 64'(lut_valid), 64'(ev));
    check("s_ready", 64'(s_ready), 64'(exp_ready));
    check("sideband", 64'(act), 64'(hold));
    run = lut_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    if (lut_valid) vcount++;
    if (cap_en && lut_valid) cap.push_back(act);
  endtask

  task automatic send_beat(input logic [63:0] d, input bit l);
    bit h;
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      h = exp_ready && !rst;
      tick();
      if (h) done = 1'b1;
    end
    s_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom);
      1:       return 16'(-1032 + int'($urandom_range(0, 15)));
      2:       return 16'(1016 + int'($urandom_range(0, 15)));
      default: return 16'(int'($urandom_range(0, 511)) - 256);
    endcase
  endfunction

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{16'h0000, 8'd128, 1'b0, 1'b0};
    tbl[1]  = '{16'h0100, 8'd160, 1'b0, 1'b0};
    tbl[2]  = '{16'hFF00, 8'd96,  1'b0, 1'b0};
    tbl[3]  = '{16'h0020, 8'd132, 1'b0, 1'b0};
    tbl[4]  = '{16'h0400, 8'd255, 1'b1, 1'b0};
    tbl[5]  = '{16'h03FF, 8'd255, 1'b0, 1'b0};
    tbl[6]  = '{16'hFC00, 8'd0,   1'b0, 1'b0};
    tbl[7]  = '{16'hFBFF, 8'd0,   1'b0, 1'b1};
    tbl[8]  = '{16'h7FFF, 8'd255, 1'b1, 1'b0};
    tbl[9]  = '{16'h8000, 8'd0,   1'b0, 1'b1};
    tbl[10] = '{16'hFFFF, 8'd127, 1'b0, 1'b0};
    tbl[11] = '{16'hFFF8, 8'd127, 1'b0, 1'b0};

    // Reset state.
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    check("ready_after_reset", 64'(s_ready), 64'd1);

    // Table beats back to back; s_last on beats 0 and 2 only.
    cap_en  = 1'b1;
    max_run = 0;
    for (int b = 0; b < 3; b++) begin
      send_beat({tbl[4*b+3].x, tbl[4*b+2].x, tbl[4*b+1].x, tbl[4*b].x}, b != 1);
    end
    for (int i = 0; i < 6; i++) tick();
    cap_en = 1'b0;
    check("continuous_run", 64'(max_run), 64'd12);
    check("table_count", 64'(cap.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < cap.size()) begin
        check("tbl_addr_flags", {cap[i].addr, cap[i].over, cap[i].under},
              {tbl[i].addr, tbl[i].over, tbl[i].under});
        check("tbl_x", 64'(cap[i].x), 64'(tbl[i].x));
        check("tbl_lane_last", {cap[i].lane, cap[i].last}, {2'(i % 4), (i == 3 || i == 11)});
      end
    end

    // Gaps with s_data toggling while nothing is accepted.
    for (int b = 0; b < 3; b++) begin
      send_beat({pick(), pick(), pick(), pick()}, 1'b1);
      for (int i = 0; i < 7; i++) begin
        s_data = {$urandom, $urandom};
        s_last = 1'($urandom);
        tick();
      end
    end

    // Reset right after lane 1 is emitted.
    send_beat({16'h0300, 16'h0200, 16'h0100, 16'h0080}, 1'b1);
    tick();
    tick();
    check("mid_lane", 64'(sb_lane), 64'd1);
    check("mid_valid", 64'(lut_valid), 64'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vcount = 0;
    tick();
    check("ready_after_rst", 64'(s_ready), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check("no_lanes_after_rst", 64'(vcount), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = {pick(), pick(), pick(), pick()};
      s_last  = 1'($urandom);
      tick();
    end
    s_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
